// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// width codes, FSM states and lane/legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } lsu_state_t;

  function automatic logic [3:0] lane_mask(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      (f3 == F3_B) || (f3 == F3_BU): m = 4'b0001 << off;
      (f3 == F3_H) || (f3 == F3_HU): m = off[1] ? 4'b1100 : 4'b0011;
      (f3 == F3_W):                  m = 4'b1111;
      default:                       m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_legal(
    input logic       store,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W): ok = 1'b1;
      (f3 == F3_BU) || (f3 == F3_HU):               ok = !store;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_aligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b1;
    unique case (1'b1)
      (f3 == F3_H) || (f3 == F3_HU): ok = !off[0];
      (f3 == F3_W):                  ok = (off == 2'b00);
      default:                       ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores and
// extract/extend for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_outdata,
  output logic [3:0]  o_we_mask,
  output logic [31:0] o_st_data,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign o_we_mask = lane_mask(i_funct3, i_off);

  always_comb begin
    o_st_data = 32'h0;
    unique case (1'b1)
      (i_funct3 == F3_B): o_st_data = {4{i_wdata[7:0]}};
      (i_funct3 == F3_H): o_st_data = {2{i_wdata[15:0]}};
      (i_funct3 == F3_W): o_st_data = i_wdata;
      default:            o_st_data = 32'h0;
    endcase
  end

  always_comb begin
    w_byte = i_outdata[7:0];
    unique case (i_off)
      2'd0: w_byte = i_outdata[7:0];
      2'd1: w_byte = i_outdata[15:8];
      2'd2: w_byte = i_outdata[23:16];
      2'd3: w_byte = i_outdata[31:24];
      default: w_byte = i_outdata[7:0];
    endcase
  end

  assign w_half = i_off[1] ? i_outdata[31:16] : i_outdata[15:0];

  always_comb begin
    o_ld_data = 32'h0;
    unique case (1'b1)
      (i_funct3 == F3_B):  o_ld_data = {{24{w_byte[7]}}, w_byte};
      (i_funct3 == F3_H):  o_ld_data = {{16{w_half[15]}}, w_half};
      (i_funct3 == F3_W):  o_ld_data = i_outdata;
      (i_funct3 == F3_BU): o_ld_data = {24'h0, w_byte};
      (i_funct3 == F3_HU): o_ld_data = {16'h0, w_half};
      default:             o_ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request capture, IDLE/ACCESS/RESP
// sequencing and the byte-enabled dmem port.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  we,
  output logic [31:0] daddr,
  output logic [31:0] indata,
  input  logic [31:0] outdata
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic        r_store;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        w_accept;
  logic        w_bad;
  logic [3:0]  w_mask;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_data;
  logic        w_wr;

  assign req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = req_ready && req_valid;
  assign w_bad     = !(is_legal(req_store, req_funct3) &&
                       is_aligned(req_funct3, req_addr[1:0]));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_next = w_bad ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_store <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store <= req_store;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_bad;
      end
    end
  end

  lsu_align u_align (
    .i_funct3  (r_f3),
    .i_off     (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_outdata (outdata),
    .o_we_mask (w_mask),
    .o_st_data (w_st_data),
    .o_ld_data (w_ld_data)
  );

  // only ACCESS ever writes; errors never reach it
  assign w_wr       = (r_state == S_ACCESS) && r_store;
  assign we         = w_wr ? w_mask : 4'b0000;
  assign indata     = w_wr ? w_st_data : 32'h0;
  assign daddr      = {r_addr[31:2], 2'b00};
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = (resp_valid && !r_store && !r_err)
                      ? w_ld_data : 32'h0;

endmodule
